// File: rtl/uart_rcvr_if.sv
// Bus bundle between the UART receive stage and its CPU-side / line-side neighbours.
// The master drives the serial line and the read strobe; the slave (receiver) returns
// the holding register contents and status flags.
interface uart_rcvr_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic                 sdi;
  logic                 rdrn;
  logic [DATA_BITS-1:0] dout;
  logic                 data_ready;
  logic                 parity_error;
  logic                 framing_error;
  logic                 overrun;

  modport master (
    output sdi,
    output rdrn,
    input  dout,
    input  data_ready,
    input  parity_error,
    input  framing_error,
    input  overrun
  );

  modport slave (
    input  sdi,
    input  rdrn,
    output dout,
    output data_ready,
    output parity_error,
    output framing_error,
    output overrun
  );

endinterface

// File: rtl/uart_rcvr.sv
// UART receive stage: 16x oversampled, start / MSB-first data / optional parity / stop.
// A single holding register presents the last frame plus its status to the CPU side.
module uart_rcvr #(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b1
) (
  input logic        clk16x,
  input logic        rst,
  uart_rcvr_if.slave bus
);

  // Bit counter only has to reach DATA_BITS-1.
  localparam int unsigned BitCntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e               state_q;
  logic [3:0]           tick_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 perr_q;

  logic                 sdi_meta_q;
  logic                 sdi_s;
  logic                 rdrn_meta_q;
  logic                 rdrn_s;
  logic                 rdrn_prev_q;

  logic                 rd_edge;
  logic                 load;

  logic [DATA_BITS-1:0] dout_q;
  logic                 data_ready_q;
  logic                 parity_error_q;
  logic                 framing_error_q;
  logic                 overrun_q;

  // Two-flop synchronisers for the asynchronous line and read strobe, plus an edge flop on rdrn.
  always_ff @(posedge clk16x) begin
    if (rst) begin
      sdi_meta_q  <= 1'b1;
      sdi_s       <= 1'b1;
      rdrn_meta_q <= 1'b1;
      rdrn_s      <= 1'b1;
      rdrn_prev_q <= 1'b1;
    end else begin
      sdi_meta_q  <= bus.sdi;
      sdi_s       <= sdi_meta_q;
      rdrn_meta_q <= bus.rdrn;
      rdrn_s      <= rdrn_meta_q;
      rdrn_prev_q <= rdrn_s;
    end
  end

  assign rd_edge = rdrn_prev_q & ~rdrn_s;

  // The stop bit is sampled mid-bit; that same cycle transfers the frame into the holding register.
  assign load = (state_q == StStop) && (tick_q == 4'd15);

  // Frame FSM: tick counter free-runs outside idle; every bit is sampled at its centre.
  always_ff @(posedge clk16x) begin
    if (rst) begin
      state_q   <= StIdle;
      tick_q    <= 4'd0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
    end else begin
      if (state_q != StIdle) begin
        tick_q <= tick_q + 4'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (!sdi_s) begin
            state_q <= StStart;
            tick_q  <= 4'd0;
          end
        end
        StStart: begin
          // Re-check the line half a bit later so short glitches are dropped silently.
          if (tick_q == 4'd7) begin
            if (!sdi_s) begin
              state_q   <= StData;
              tick_q    <= 4'd0;
              bit_cnt_q <= '0;
              perr_q    <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StData: begin
          if (tick_q == 4'd15) begin
            shreg_q <= DATA_BITS'({shreg_q, sdi_s});
            if (bit_cnt_q == LastBit) begin
              bit_cnt_q <= '0;
              state_q   <= PARITY_EN ? StParity : StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (tick_q == 4'd15) begin
            perr_q  <= ((^shreg_q) ^ sdi_s) != PARITY_ODD;
            state_q <= StStop;
          end
        end
        StStop: begin
          // Leaving mid-stop-bit leaves room to catch a back-to-back start edge.
          if (tick_q == 4'd15) begin
            state_q <= sdi_s ? StIdle : StBreak;
          end
        end
        StBreak: begin
          // A held-low line reports one framing error, then waits for the line to recover.
          if (sdi_s) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Holding register: a new frame has priority over a CPU read landing on the same cycle.
  always_ff @(posedge clk16x) begin
    if (rst) begin
      dout_q          <= '0;
      data_ready_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else if (load) begin
      dout_q          <= shreg_q;
      data_ready_q    <= 1'b1;
      parity_error_q  <= PARITY_EN ? perr_q : 1'b0;
      framing_error_q <= ~sdi_s;
      if (data_ready_q && !rd_edge) begin
        overrun_q <= 1'b1;
      end
    end else if (rd_edge && data_ready_q) begin
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.data_ready    = data_ready_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;
  assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rcvr.sv
// Bench for uart_rcvr: directed frames followed by randomized frames, checked against a
// frame-level model of the holding register.
module tb_uart_rcvr;

  localparam int unsigned DataBits  = 8;
  localparam bit          ParityEn  = 1'b1;
  localparam bit          ParityOdd = 1'b1;
  localparam int unsigned BitClks   = 16;

  logic clk16x = 1'b0;
  logic rst;

  always #5 clk16x = ~clk16x;

  uart_rcvr_if #(.DATA_BITS(DataBits)) bus ();

  uart_rcvr #(
    .DATA_BITS (DataBits),
    .PARITY_EN (ParityEn),
    .PARITY_ODD(ParityOdd)
  ) dut (
    .clk16x(clk16x),
    .rst   (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level model of what the CPU should see.
  logic [DataBits-1:0] exp_dout;
  logic                exp_ready;
  logic                exp_perr;
  logic                exp_ferr;
  logic                exp_overrun;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".dout"},     32'(bus.dout),          32'(exp_dout));
    check_eq({tag, ".ready"},    32'(bus.data_ready),    32'(exp_ready));
    check_eq({tag, ".perr"},     32'(bus.parity_error),  32'(exp_perr));
    check_eq({tag, ".ferr"},     32'(bus.framing_error), 32'(exp_ferr));
    check_eq({tag, ".overrun"},  32'(bus.overrun),       32'(exp_overrun));
  endtask

  task automatic model_reset();
    exp_dout    = '0;
    exp_ready   = 1'b0;
    exp_perr    = 1'b0;
    exp_ferr    = 1'b0;
    exp_overrun = 1'b0;
  endtask

  // Parity bit a correct transmitter would append.
  function automatic logic good_parity(input logic [DataBits-1:0] d);
    int ones = $countones(d);
    if (ParityOdd) return (ones % 2 == 0);
    return (ones % 2 == 1);
  endfunction

  task automatic model_frame(input logic [DataBits-1:0] d, input logic p, input logic stop);
    if (exp_ready) exp_overrun = 1'b1;
    exp_ready = 1'b1;
    exp_dout  = d;
    exp_perr  = ParityEn && (p != good_parity(d));
    exp_ferr  = !stop;
  endtask

  task automatic model_read();
    if (exp_ready) begin
      exp_ready   = 1'b0;
      exp_overrun = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic b, input int unsigned n);
    bus.sdi = b;
    repeat (n) @(negedge clk16x);
  endtask

  // Whole frame; a low stop bit keeps the line low for extra bit-times then idles one bit.
  task automatic send_frame(input logic [DataBits-1:0] d, input logic p, input logic stop,
                            input int unsigned hold_low_bits);
    drive_bit(1'b0, BitClks);
    for (int i = int'(DataBits) - 1; i >= 0; i--) drive_bit(d[i], BitClks);
    if (ParityEn) drive_bit(p, BitClks);
    drive_bit(stop, BitClks);
    if (!stop) begin
      drive_bit(1'b0, BitClks * hold_low_bits);
      drive_bit(1'b1, BitClks);
    end
    model_frame(d, p, stop);
  endtask

  task automatic do_read();
    bus.rdrn = 1'b0;
    repeat (4) @(negedge clk16x);
    bus.rdrn = 1'b1;
    repeat (4) @(negedge clk16x);
    model_read();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DataBits-1:0] d;
    logic                p;
    logic                stop;

    bus.sdi  = 1'b1;
    bus.rdrn = 1'b1;
    rst      = 1'b1;
    model_reset();
    repeat (3) @(negedge clk16x);
    rst = 1'b0;
    check_outputs("reset");
    drive_bit(1'b1, BitClks);

    // Clean frame.
    send_frame(8'hA5, good_parity(8'hA5), 1'b1, 0);
    check_outputs("a5");
    do_read();
    check_outputs("a5_read");

    // Short low glitch must not start a frame.
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 2 * BitClks);
    check_outputs("glitch");
    send_frame(8'h3C, good_parity(8'h3C), 1'b1, 0);
    check_outputs("3c");
    do_read();

    // Wrong parity bit.
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    check_outputs("perr");
    do_read();

    // Low stop bit, line held low: exactly one load.
    send_frame(8'h0F, good_parity(8'h0F), 1'b0, 40);
    check_outputs("break");
    do_read();
    check_outputs("break_read");
    send_frame(8'h5A, good_parity(8'h5A), 1'b1, 0);
    check_outputs("after_break");
    do_read();

    // Two frames without a read.
    send_frame(8'h11, good_parity(8'h11), 1'b1, 0);
    send_frame(8'h22, good_parity(8'h22), 1'b1, 0);
    check_outputs("overrun");
    do_read();
    check_outputs("overrun_read");

    // Reset in the middle of a frame, with a flagged byte still held.
    send_frame(8'h81, 1'b0, 1'b1, 0);
    check_outputs("pre_rst");
    drive_bit(1'b0, BitClks);
    drive_bit(1'b0, BitClks);
    drive_bit(1'b1, BitClks);
    drive_bit(1'b0, BitClks / 2);
    rst     = 1'b1;
    bus.sdi = 1'b1;
    @(negedge clk16x);
    model_reset();
    check_outputs("mid_rst");
    rst = 1'b0;
    drive_bit(1'b1, 2 * BitClks);
    check_outputs("post_rst");
    send_frame(8'h55, good_parity(8'h55), 1'b1, 0);
    check_outputs("55");
    do_read();

    // Randomized frames: parity and stop faults, random gaps, reads skipped at random.
    for (int n = 0; n < 40; n++) begin
      d    = DataBits'($urandom);
      p    = good_parity(d);
      if ($urandom_range(0, 4) == 0) p = ~p;
      stop = ($urandom_range(0, 9) != 0);
      send_frame(d, p, stop, $urandom_range(0, 3));
      check_outputs($sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        do_read();
        check_eq($sformatf("rnd%0d.read_ready", n), 32'(bus.data_ready), 32'(exp_ready));
        check_eq($sformatf("rnd%0d.read_ovr", n), 32'(bus.overrun), 32'(exp_overrun));
      end
      drive_bit(1'b1, $urandom_range(0, 20));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
